// File: rtl/dbg_reg_reader.sv
// Debug register readback: decodes single-nibble / burst read commands, snapshots the
// selected register and streams it out as {tag, nibble} bytes over the tx_en/tx_busy
// handshake, least-significant nibble first, with a one-cycle gap after every byte.
module dbg_reg_reader #(
  parameter int         NUM_REGS   = 8,
  parameter int         REG_W      = 16,
  parameter logic [3:0] CMD_SINGLE = 4'h2,
  parameter logic [3:0] CMD_BURST  = 4'h3,
  parameter logic [3:0] ERR_TAG    = 4'hF
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                opcode,
  input  logic                      en,
  input  logic [NUM_REGS*REG_W-1:0] regs_flat,
  input  logic                      tx_busy,
  output logic                      tx_en,
  output logic [7:0]                tx_data,
  output logic                      busy
);

  localparam int NIBS = REG_W / 4;
  localparam int CW   = $clog2(NIBS + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [3:0]       tag;
  logic [REG_W-1:0] snap;

  logic             is_single, is_burst;
  logic [31:0]      idx, reg_sel, nib_sel;
  logic             in_range;
  logic [REG_W-1:0] sel_reg;
  logic [3:0]       sel_nib;

  // Command decode: register/nibble select with full-width unsigned range check
  always_comb begin
    is_single = (opcode[7:4] == CMD_SINGLE);
    is_burst  = (opcode[7:4] == CMD_BURST);
    idx       = {28'd0, opcode[3:0]};
    reg_sel   = is_single ? (idx / 32'(NIBS)) : idx;
    nib_sel   = is_single ? (idx % 32'(NIBS)) : 32'd0;
    in_range  = (reg_sel < 32'(NUM_REGS));
    sel_reg   = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (reg_sel == 32'(i)) sel_reg = regs_flat[i*REG_W +: REG_W];
    sel_nib   = 4'h0;
    for (int j = 0; j < NIBS; j++)
      if (nib_sel == 32'(j)) sel_nib = sel_reg[j*4 +: 4];
  end

  // Control FSM: accept in IDLE, issue a byte in SEND once the UART is free, GAP masks busy latency
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      tag     <= 4'h0;
      snap    <= '0;
      tx_en   <= 1'b0;
      tx_data <= 8'h00;
      busy    <= 1'b0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        S_IDLE: begin
          if (en && is_single) begin
            state <= S_SEND;
            busy  <= 1'b1;
            cnt   <= CW'(1);
            tag   <= in_range ? CMD_SINGLE : ERR_TAG;
            snap  <= in_range ? REG_W'(sel_nib) : '0;
          end else if (en && is_burst) begin
            state <= S_SEND;
            busy  <= 1'b1;
            if (in_range) begin
              cnt  <= CW'(NIBS);
              tag  <= CMD_BURST;
              snap <= sel_reg;
            end else begin
              cnt  <= CW'(1);
              tag  <= ERR_TAG;
              snap <= '0;
            end
          end
        end
        S_SEND: begin
          if (!tx_busy) begin
            tx_en   <= 1'b1;
            tx_data <= {tag, snap[3:0]};
            cnt     <= cnt - CW'(1);
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          if (cnt != '0) begin
            snap  <= snap >> 4;
            state <= S_SEND;
          end else begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_reg_reader.sv
// Scoreboard bench for dbg_reg_reader: directed commands push expected reply bytes,
// a negedge monitor pops and compares on every tx_en.
module tb_dbg_reg_reader;

  localparam int NUM_REGS = 4;
  localparam int REG_W    = 16;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [7:0]                opcode;
  logic                      en;
  logic [NUM_REGS*REG_W-1:0] regs_flat;
  logic                      tx_busy;
  logic                      tx_en;
  logic [7:0]                tx_data;
  logic                      busy;

  int checks   = 0;
  int failures = 0;
  int rx_cnt   = 0;
  logic [7:0] exp_q[$];
  logic prev_en = 1'b0;
  logic busy_at_edge = 1'b0;

  dbg_reg_reader #(.NUM_REGS(NUM_REGS), .REG_W(REG_W)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .en(en), .regs_flat(regs_flat),
    .tx_busy(tx_busy), .tx_en(tx_en), .tx_data(tx_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // tx_busy as the DUT saw it at the most recent active edge
  always @(posedge clk) busy_at_edge <= tx_busy;

  // Monitor: pop and compare each emitted byte, check spacing and handshake
  always @(negedge clk) begin
    if (rst_n && tx_en) begin
      checks++;
      if (prev_en) begin
        failures++;
        $display("FAIL back_to_back_tx_en actual=1 required=0");
      end
      checks++;
      if (busy_at_edge) begin
        failures++;
        $display("FAIL tx_en_while_tx_busy actual=1 required=0");
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte actual=%h required=none", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          failures++;
          $display("FAIL tx_data actual=%h required=%h", tx_data, e);
        end
      end
      rx_cnt++;
    end
    prev_en = tx_en;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic cmd(input logic [7:0] op);
    @(negedge clk); opcode = op; en = 1'b1;
    @(negedge clk); en = 1'b0;
  endtask

  task automatic set_reg(input int r, input logic [15:0] v);
    regs_flat[r*REG_W +: REG_W] = v;
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk); n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_timeout actual=busy required=idle", nm);
    end
    @(negedge clk);
    chk({nm, "_queue_left"}, 8'(exp_q.size()), 8'd0);
  endtask

  initial begin
    int target;
    rst_n = 1'b0; en = 1'b0; opcode = 8'h00; tx_busy = 1'b0; regs_flat = '0;
    set_reg(0, 16'h1234); set_reg(1, 16'h5678); set_reg(2, 16'hBEEF); set_reg(3, 16'hA5C7);
    repeat (3) @(negedge clk);
    chk("rst_tx_en", 8'(tx_en), 8'd0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", 8'(busy), 8'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single read with latency/busy timing
    exp_q.push_back(8'h23);
    cmd(8'h21);
    chk("single_lat_n0_tx_en", 8'(tx_en), 8'd0);
    chk("single_busy_n0", 8'(busy), 8'd1);
    @(negedge clk);
    chk("single_lat_n1_tx_en", 8'(tx_en), 8'd1);
    chk("single_busy_n1", 8'(busy), 8'd1);
    @(negedge clk);
    chk("single_busy_n2", 8'(busy), 8'd0);
    wait_idle("single");

    // Burst read of reg2
    exp_q.push_back(8'h3F); exp_q.push_back(8'h3E); exp_q.push_back(8'h3E); exp_q.push_back(8'h3B);
    cmd(8'h32);
    wait_idle("burst");

    // Snapshot: reg2 cleared right after accept
    exp_q.push_back(8'h3F); exp_q.push_back(8'h3E); exp_q.push_back(8'h3E); exp_q.push_back(8'h3B);
    cmd(8'h32);
    set_reg(2, 16'h0000);
    wait_idle("snapshot");
    set_reg(2, 16'hBEEF);

    // Handshake hold, also flat index 15 -> reg3 nibble 3
    tx_busy = 1'b1;
    exp_q.push_back(8'h2A);
    cmd(8'h2F);
    repeat (50) @(negedge clk);
    chk("hold_no_tx", 8'(rx_cnt == 0 ? 0 : exp_q.size()), 8'd1);
    tx_busy = 1'b0;
    wait_idle("hold");

    // en while busy ignored
    exp_q.push_back(8'h34); exp_q.push_back(8'h33); exp_q.push_back(8'h32); exp_q.push_back(8'h31);
    cmd(8'h30);
    cmd(8'h21);
    wait_idle("en_while_busy");

    // Out-of-range burst select -> error byte
    exp_q.push_back(8'hF0);
    cmd(8'h37);
    wait_idle("err_burst");

    // Unknown opcode -> no response
    cmd(8'h55);
    chk("ignored_busy", 8'(busy), 8'd0);
    repeat (10) @(negedge clk);
    chk("ignored_busy_late", 8'(busy), 8'd0);

    // Reset after the second burst byte
    exp_q.push_back(8'h3F); exp_q.push_back(8'h3E); exp_q.push_back(8'h3E); exp_q.push_back(8'h3B);
    target = rx_cnt + 2;
    cmd(8'h32);
    for (int i = 0; i < 40 && rx_cnt < target; i++) begin
      @(negedge clk); #1;
    end
    chk("mid_reset_reached_2nd", 8'(rx_cnt >= target), 8'd1);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_reset_tx_en", 8'(tx_en), 8'd0);
    chk("mid_reset_busy", 8'(busy), 8'd0);
    chk("mid_reset_pending", 8'(exp_q.size()), 8'd2);
    exp_q.delete();
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_reset_quiet_busy", 8'(busy), 8'd0);

    // Normal operation after reset
    exp_q.push_back(8'h3F); exp_q.push_back(8'h3E); exp_q.push_back(8'h3E); exp_q.push_back(8'h3B);
    cmd(8'h32);
    wait_idle("post_reset_burst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
